mem_access_unit: RTL and testbench

- Load/store sequencer directly upstream of the SimpleCPU data memory.
- Accepts CPU load/store requests over a valid/ready handshake and buffers them in a small FIFO.
- Drives the memory's address/val/load port with exactly one-cycle write pulses.
- Returns load data or store acknowledgements over a valid/ready response channel.

---
 rtl/mau_pkg.sv | 22 ++
 rtl/mem_access_unit_if.sv | 42 ++++
 rtl/mau_req_fifo.sv | 60 ++++++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mau_pkg.sv
// Shared definitions for the memory access unit.
// Holds the sequencer state encoding, the default port widths and a request
// record at those default widths (the bench uses it for stimulus).
package mau_pkg;

    localparam int MAU_ADDR_W = 2;
    localparam int MAU_DATA_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_CAPTURE,
        ST_RESP
    } mau_state_t;

    typedef struct packed {
        logic                  we;
        logic [MAU_ADDR_W-1:0] addr;
        logic [MAU_DATA_W-1:0] wdata;
    } mau_req_t;

endpackage

// File: rtl/mem_access_unit_if.sv
// Bus bundle between the CPU, the memory access unit and the data memory.
//   req_*  : CPU request channel (valid/ready), we=1 store, we=0 load
//   rsp_*  : response channel (valid/ready), rdata is 0 for stores
//   mem_*  : memory port; mem_load=0 is a write, mem_rdata comes back
//   busy   : unit has work buffered or in flight
// slave  : the unit's view.  master : the CPU + memory side.
interface mem_access_unit_if import mau_pkg::*; #(
    parameter int ADDR_W = MAU_ADDR_W,
    parameter int DATA_W = MAU_DATA_W
);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_is_store;
    logic [DATA_W-1:0] rsp_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_val;
    logic              mem_load;
    logic [DATA_W-1:0] mem_rdata;

    logic              busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_is_store, rsp_rdata,
               mem_addr, mem_val, mem_load, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_is_store, rsp_rdata,
               mem_addr, mem_val, mem_load, busy
    );

endinterface

// File: rtl/mau_req_fifo.sv
// Request FIFO for the memory access unit.
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push/wdata : write an entry (ignored when full)
//   pop/rdata  : rdata shows the head; pop drops it (ignored when empty)
//   full/empty/count : occupancy, count is clog2(DEPTH)+1 bits
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module mau_req_fifo import mau_pkg::*; #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] store_q;
    logic [PTR_W-1:0]            wr_ptr_q;
    logic [PTR_W-1:0]            rd_ptr_q;
    logic [CNT_W-1:0]            count_q;
    logic                        do_push;
    logic                        do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = store_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Payload needs no reset: it is only read when count says it is valid.
    always_ff @(posedge clk) begin
        if (do_push) store_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory.
//   clk, rst_n : clock, async active-low reset (drops all queued work)
//   bus        : slave side of mem_access_unit_if (request, response,
//                memory port, busy)
// Requests are buffered in a small FIFO and executed one at a time:
// IDLE (pop) -> ISSUE (drive port, write pulse for stores) -> CAPTURE
// (register load data) -> RESP (wait for rsp_ready).
module mem_access_unit import mau_pkg::*; #(
    parameter int ADDR_W = MAU_ADDR_W,
    parameter int DATA_W = MAU_DATA_W,
    parameter int DEPTH  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);

    localparam int CMD_W = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    mau_state_t        state_q, state_d;
    cmd_t              push_cmd, head_cmd, cmd_q;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic [CNT_W-1:0]  fifo_count;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_val_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_is_store_q;
    logic              mem_load_d;
    logic              rsp_valid_d;

    assign push_cmd  = {bus.req_we, bus.req_addr, bus.req_wdata};
    assign fifo_push = bus.req_valid && !fifo_full;

    // A same-cycle pop does not open a slot for the incoming request.
    assign bus.req_ready = (fifo_count < CNT_W'(DEPTH));

    mau_req_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .wdata (push_cmd),
        .pop   (fifo_pop),
        .rdata (head_cmd),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d     = state_q;
        fifo_pop    = 1'b0;
        mem_load_d  = 1'b1;
        rsp_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    state_d  = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Only state that can write: the pulse is exactly this cycle.
                mem_load_d = ~cmd_q.we;
                state_d    = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid_d = 1'b1;
                if (bus.rsp_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            cmd_q          <= '0;
            mem_addr_q     <= '0;
            mem_val_q      <= '0;
            rsp_rdata_q    <= '0;
            rsp_is_store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // Port address/data are loaded on pop so they are already valid
            // in ISSUE, then simply held until the next command.
            if (fifo_pop) begin
                cmd_q      <= head_cmd;
                mem_addr_q <= head_cmd.addr;
                mem_val_q  <= head_cmd.wdata;
            end
            // mem_rdata is only looked at for loads, so a floating memory
            // output during stores cannot reach the response.
            if (state_q == ST_CAPTURE) begin
                rsp_is_store_q <= cmd_q.we;
                rsp_rdata_q    <= cmd_q.we ? '0 : bus.mem_rdata;
            end
        end
    end

    assign bus.mem_addr     = mem_addr_q;
    assign bus.mem_val      = mem_val_q;
    assign bus.mem_load     = mem_load_d;
    assign bus.rsp_valid    = rsp_valid_d;
    assign bus.rsp_rdata    = rsp_rdata_q;
    assign bus.rsp_is_store = rsp_is_store_q;
    assign bus.busy         = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a memory model on the port, a
// reference model that predicts every response at accept time from a
// shadow memory, and one task per scenario.
module tb_mem_access_unit;
    import mau_pkg::*;

    localparam int AW    = MAU_ADDR_W;
    localparam int DW    = MAU_DATA_W;
    localparam int DEPTH = 2;
    localparam int NLOC  = 1 << AW;

    typedef struct packed {
        logic          is_store;
        logic [DW-1:0] rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic mem_clr = 1'b1;
    logic z_all = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    mem_access_unit_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // Memory: synchronous write while mem_load=0, output undriven except
    // while loading.
    logic [DW-1:0] mem_arr [NLOC];
    assign bus.mem_rdata = (z_all || !bus.mem_load) ? 'x : mem_arr[bus.mem_addr];

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < NLOC; i++) mem_arr[i] <= '0;
        end else if (!bus.mem_load) begin
            mem_arr[bus.mem_addr] <= bus.mem_val;
        end
    end

    // Observation + reference model.
    rsp_t          exp_q[$];
    rsp_t          obs_q[$];
    logic [AW+DW-1:0] wr_q[$];
    logic [DW-1:0] model_mem [NLOC];
    int            wide_pulse = 0;
    int            unstable = 0;
    logic          prev_load0 = 1'b0;
    logic          prev_hold = 1'b0;
    rsp_t          prev_rsp = '0;

    always @(negedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < NLOC; i++) model_mem[i] <= '0;
        end
        if (!rst_n) begin
            prev_load0 <= 1'b0;
            prev_hold  <= 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    exp_q.push_back(rsp_t'({1'b1, {DW{1'b0}}}));
                    model_mem[bus.req_addr] <= bus.req_wdata;
                end else begin
                    exp_q.push_back(rsp_t'({1'b0, model_mem[bus.req_addr]}));
                end
            end
            if (bus.rsp_valid && bus.rsp_ready)
                obs_q.push_back(rsp_t'({bus.rsp_is_store, bus.rsp_rdata}));
            if (!bus.mem_load) begin
                wr_q.push_back({bus.mem_addr, bus.mem_val});
                if (prev_load0) wide_pulse <= wide_pulse + 1;
            end
            if (prev_hold && (!bus.rsp_valid ||
                              rsp_t'({bus.rsp_is_store, bus.rsp_rdata}) !== prev_rsp))
                unstable <= unstable + 1;
            prev_hold  <= bus.rsp_valid && !bus.rsp_ready;
            prev_rsp   <= rsp_t'({bus.rsp_is_store, bus.rsp_rdata});
            prev_load0 <= !bus.mem_load;
        end
    end

    // Stimulus helpers (called at posedge+1).
    task automatic send_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.req_ready && n < 300);
        if (!bus.req_ready) begin
            checks++; errors++;
            $display("FAIL send_req_timeout: req_ready=%0b after %0d cycles, want 1", bus.req_ready, n);
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy && n < 1000);
        if (bus.busy) begin
            checks++; errors++;
            $display("FAIL wait_idle_timeout: busy=%0b after %0d cycles, want 0", bus.busy, n);
        end
        @(posedge clk); #1;
    endtask

    task automatic clear_obs();
        exp_q.delete();
        obs_q.delete();
        wr_q.delete();
    endtask

    // Scenarios.
    task automatic test_reset();
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
        bus.req_wdata = '0;   bus.rsp_ready = 1'b0;
        rst_n = 1'b0; mem_clr = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_is_store, bus.mem_load, bus.busy} !== 5'b10010) begin
            errors++;
            $display("FAIL reset_ctrl: ready/valid/is_store/load/busy=%b want 10010",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_is_store, bus.mem_load, bus.busy});
        end
        checks++;
        if ({bus.rsp_rdata, bus.mem_addr, bus.mem_val} !== '0) begin
            errors++;
            $display("FAIL reset_data: rdata=%0d addr=%0d val=%0d want 0 0 0",
                     bus.rsp_rdata, bus.mem_addr, bus.mem_val);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; mem_clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_load, bus.req_ready, bus.rsp_valid, bus.busy} !== 4'b1100) begin
                errors++;
                $display("FAIL idle[%0d]: load/ready/valid/busy=%b want 1100", i,
                         {bus.mem_load, bus.req_ready, bus.rsp_valid, bus.busy});
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        int wp0 = wide_pulse;
        clear_obs();
        bus.rsp_ready = 1'b1;
        send_req(1'b1, 2'd2, 2'd3);
        send_req(1'b0, 2'd2, 2'd0);
        wait_idle();
        checks++;
        if (obs_q.size() !== 2) begin
            errors++; $display("FAIL sl_count: got %0d responses want 2", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0] !== rsp_t'({1'b1, 2'd0})) begin
                errors++; $display("FAIL sl_store_rsp: got is_store=%0b rdata=%0d want 1 0",
                                   obs_q[0].is_store, obs_q[0].rdata);
            end
            checks++;
            if (obs_q[1] !== rsp_t'({1'b0, 2'd3})) begin
                errors++; $display("FAIL sl_load_rsp: got is_store=%0b rdata=%0d want 0 3",
                                   obs_q[1].is_store, obs_q[1].rdata);
            end
        end
        checks++;
        if (wr_q.size() !== 1 || wr_q[0] !== {2'd2, 2'd3}) begin
            errors++; $display("FAIL sl_write: got %0d write cycles first addr/val=%h want 1 cycle a=2 v=3",
                               wr_q.size(), wr_q.size() > 0 ? wr_q[0] : '0);
        end
        checks++;
        if (wide_pulse !== wp0) begin
            errors++; $display("FAIL sl_pulse: got %0d multi-cycle write pulses want 0", wide_pulse - wp0);
        end
    endtask

    task automatic test_latency();
        logic seen;
        clear_obs();
        bus.rsp_ready = 1'b0;
        send_req(1'b0, 2'd2, 2'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            seen = bus.rsp_valid;
            checks++;
            if (seen !== (k == 3)) begin
                errors++; $display("FAIL latency[%0d]: rsp_valid=%0b want %0b", k, seen, k == 3);
            end
        end
        checks++;
        if (exp_q.size() !== 1 || rsp_t'({bus.rsp_is_store, bus.rsp_rdata}) !== exp_q[0]) begin
            errors++; $display("FAIL latency_data: got is_store=%0b rdata=%0d want is_store=0 rdata=%0d",
                               bus.rsp_is_store, bus.rsp_rdata, exp_q.size() > 0 ? exp_q[0].rdata : '0);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_backpressure();
        int us0 = unstable;
        logic [DW-1:0] d4;
        clear_obs();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send_req(1'($urandom), AW'($urandom), DW'($urandom));
        d4 = DW'($urandom);
        bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 2'd1; bus.req_wdata = d4;
        for (int i = 0; i < 8; i++) @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.busy} !== 3'b011) begin
            errors++; $display("FAIL bp_full: ready/valid/busy=%b want 011",
                               {bus.req_ready, bus.rsp_valid, bus.busy});
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        send_req(1'b0, 2'd1, d4);
        wait_idle();
        checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() !== 4) begin
            errors++; $display("FAIL bp_count: got %0d responses want %0d (model %0d)",
                               obs_q.size(), 4, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL bp_order[%0d]: got is_store=%0b rdata=%0d want is_store=%0b rdata=%0d",
                                   i, obs_q[i].is_store, obs_q[i].rdata, exp_q[i].is_store, exp_q[i].rdata);
            end
        end
        checks++;
        if (unstable !== us0) begin
            errors++; $display("FAIL bp_stable: got %0d unstable held cycles want 0", unstable - us0);
        end
    endtask

    task automatic test_wrap();
        clear_obs();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_req(1'b1, AW'(i), DW'((i + 1) % 4));
        for (int i = 0; i < 4; i++) send_req(1'b0, AW'(i), DW'($urandom));
        wait_idle();
        checks++;
        if (obs_q.size() !== 8 || wr_q.size() !== 4) begin
            errors++; $display("FAIL wrap_count: got %0d responses %0d writes want 8 4",
                               obs_q.size(), wr_q.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (obs_q[i] !== (i < 4 ? rsp_t'({1'b1, 2'd0}) : rsp_t'({1'b0, DW'((i - 3) % 4)}))) begin
                    errors++; $display("FAIL wrap_rsp[%0d]: got is_store=%0b rdata=%0d want is_store=%0b rdata=%0d",
                                       i, obs_q[i].is_store, obs_q[i].rdata, i < 4, i < 4 ? 0 : (i - 3) % 4);
                end
            end
        end
    endtask

    task automatic test_z_rdata();
        clear_obs();
        z_all = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_req(1'b1, AW'($urandom), DW'($urandom));
        wait_idle();
        z_all = 1'b0;
        checks++;
        if (obs_q.size() !== 4) begin
            errors++; $display("FAIL z_count: got %0d responses want 4", obs_q.size());
        end
        for (int i = 0; i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== rsp_t'({1'b1, 2'd0})) begin
                errors++; $display("FAIL z_store_rsp[%0d]: got is_store=%b rdata=%b want 1 00",
                                   i, obs_q[i].is_store, obs_q[i].rdata);
            end
        end
    endtask

    task automatic test_random();
        int wp0 = wide_pulse;
        int us0 = unstable;
        int nst = 0;
        logic done = 1'b0;
        mau_req_t r;
        clear_obs();
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                    r.we = 1'($urandom); r.addr = AW'($urandom); r.wdata = DW'($urandom);
                    send_req(r.we, r.addr, r.wdata);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    bus.rsp_ready = 1'($urandom);
                end
            end
        join
        bus.rsp_ready = 1'b1;
        wait_idle();
        checks++;
        if (obs_q.size() !== exp_q.size() || exp_q.size() !== 60) begin
            errors++; $display("FAIL rand_count: got %0d responses want 60 (model %0d)",
                               obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            if (exp_q[i].is_store) nst++;
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL rand_rsp[%0d]: got is_store=%0b rdata=%0d want is_store=%0b rdata=%0d",
                                   i, obs_q[i].is_store, obs_q[i].rdata, exp_q[i].is_store, exp_q[i].rdata);
            end
        end
        checks++;
        if (wr_q.size() !== nst || wide_pulse !== wp0 || unstable !== us0) begin
            errors++; $display("FAIL rand_port: writes=%0d wide=%0d unstable=%0d want %0d 0 0",
                               wr_q.size(), wide_pulse - wp0, unstable - us0, nst);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        bus.rsp_ready = 1'b1;
        send_req(1'b0, 2'd3, 2'd0);
        send_req(1'b0, 2'd1, 2'd0);
        // Head load is now in ISSUE, second load still queued.
        checks++;
        if (bus.mem_addr !== 2'd3 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL rm_issue: mem_addr=%0d busy=%0b want 3 1", bus.mem_addr, bus.busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.req_ready, bus.rsp_valid, bus.rsp_is_store, bus.mem_load, bus.busy} !== 5'b10010 ||
            {bus.rsp_rdata, bus.mem_addr, bus.mem_val} !== '0) begin
            errors++; $display("FAIL rm_async: ready/valid/is_store/load/busy=%b rdata=%0d addr=%0d val=%0d want 10010 0 0 0",
                               {bus.req_ready, bus.rsp_valid, bus.rsp_is_store, bus.mem_load, bus.busy},
                               bus.rsp_rdata, bus.mem_addr, bus.mem_val);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_obs();
        for (int i = 0; i < 20; i++) @(negedge clk);
        checks++;
        if (obs_q.size() !== 0 || wr_q.size() !== 0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL rm_dropped: responses=%0d writes=%0d busy=%0b want 0 0 0",
                               obs_q.size(), wr_q.size(), bus.busy);
        end
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_store_load();
        test_latency();
        test_backpressure();
        test_wrap();
        test_z_rdata();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
